seq_divider: RTL and testbench

Parametrised sequential unsigned integer divider. It replaces the fixed 4-bit divider control unit and datapath pair with one block whose operand width is set at elaboration. It computes quotient and remainder by restoring division, one quotient bit per clock, under a go/done handshake. It sits between the operand-entry logic and the result display path of the divider top level.

---
 rtl/seq_divider_pkg.sv | 13 +
 rtl/seq_divider_ctrl.sv | 74 +++++++
 rtl/seq_divider.sv | 116 +++++++++++
 tb/tb_seq_divider.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding
// and the width of the debug state code.
package seq_divider_pkg;

   localparam int CS_W = 2;

   typedef enum logic [CS_W-1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_divider_ctrl.sv
// Control unit for seq_divider: state register, iteration counter,
// next-state logic and the one-cycle enables that steer the datapath.
// The encoding 2'd3 is never entered normally; if it ever appears the
// block falls back to IDLE on the next edge.
module seq_divider_ctrl
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            go,
   input  logic            dbz,       // zero divisor request, already qualified by the top
   output logic [CS_W-1:0] state,
   output logic            load,      // accept operands, start iterating
   output logic            step,      // one restoring-division iteration this edge
   output logic            finish,    // last iteration, latch results
   output logic            dbz_load   // zero divisor, latch the fixed result
);

   logic [CS_W-1:0]  state_q, state_d;
   logic [CNT_W-1:0] cnt;

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Iteration counter: loaded with WIDTH on accept, counts down per iteration
   always_ff @(posedge clk) begin
      if (rst)       cnt <= '0;
      else if (load) cnt <= CNT_W'(WIDTH);
      else if (step) cnt <= cnt - 1'b1;
   end

   // Next-state and datapath enables
   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      step     = 1'b0;
      finish   = 1'b0;
      dbz_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (go) begin
               if (dbz) begin
                  dbz_load = 1'b1;
                  state_d  = DONE;
               end else begin
                  load    = 1'b1;
                  state_d = ITER;
               end
            end
         end
         ITER: begin
            step = 1'b1;
            if (cnt == CNT_W'(1)) begin
               finish  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            // stay while go is held so a long go pulse cannot restart
            if (!go) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign state = state_q;

endmodule

// File: rtl/seq_divider.sv
// Parametrised sequential unsigned divider (restoring, one quotient bit per
// clock) with a go/done handshake. The control unit lives in
// seq_divider_ctrl; the shift/subtract datapath and result registers live here.
// Optional feature: define DIVIDER_DBZ_CHECK_EN to short-circuit a zero
// divisor straight to DONE with err set; otherwise err is tied low and a
// zero divisor runs the normal iterations.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             done,
   output logic             busy,
   output logic             err,
   output logic [1:0]       cs
);

   logic [CS_W-1:0] state;
   logic            load, step, finish, dbz_load, dbz;

   logic [WIDTH-1:0] x_reg, y_reg;
   logic [WIDTH:0]   r_reg;
   logic [WIDTH:0]   t, diff, r_nxt;
   logic [WIDTH-1:0] x_nxt;
   logic             ge;

`ifdef DIVIDER_DBZ_CHECK_EN
   assign dbz = (divisor == '0);
`else
   assign dbz = 1'b0;
`endif

   seq_divider_ctrl #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_ctrl (
      .clk      (clk),
      .rst      (rst),
      .go       (go),
      .dbz      (dbz),
      .state    (state),
      .load     (load),
      .step     (step),
      .finish   (finish),
      .dbz_load (dbz_load)
   );

   // One restoring step: shift the next dividend bit into the partial
   // remainder, subtract the divisor if it fits, record the quotient bit.
   always_comb begin
      t     = {r_reg[WIDTH-1:0], x_reg[WIDTH-1]};
      ge    = (t >= {1'b0, y_reg});
      diff  = t - {1'b0, y_reg};
      r_nxt = ge ? diff : t;
      x_nxt = {x_reg[WIDTH-2:0], ge};
   end

   // Working registers: capture on accept, advance on each iteration
   always_ff @(posedge clk) begin
      if (rst) begin
         x_reg <= '0;
         y_reg <= '0;
         r_reg <= '0;
      end else if (load) begin
         x_reg <= dividend;
         y_reg <= divisor;
         r_reg <= '0;
      end else if (step) begin
         x_reg <= x_nxt;
         r_reg <= r_nxt;
      end
   end

   // Result registers: hold the last result until the next one completes
   always_ff @(posedge clk) begin
      if (rst) begin
         quotient  <= '0;
         remainder <= '0;
      end else if (finish) begin
         quotient  <= x_nxt;
         remainder <= r_nxt[WIDTH-1:0];
      end else if (dbz_load) begin
         quotient  <= '1;
         remainder <= dividend;
      end
   end

`ifdef DIVIDER_DBZ_CHECK_EN
   // Divide-by-zero flag: set on a short-circuited request, cleared on accept
   always_ff @(posedge clk) begin
      if (rst)           err <= 1'b0;
      else if (load)     err <= 1'b0;
      else if (dbz_load) err <= 1'b1;
   end
`else
   assign err = 1'b0;
`endif

   // The partial remainder never exceeds the divisor, so its top bit is
   // always zero after a step; it is kept for width symmetry only.
   logic unused_rtop;
   assign unused_rtop = r_reg[WIDTH] ^ r_nxt[WIDTH];

   assign done = (state == DONE);
   assign busy = (state == ITER);
   assign cs   = state;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: a 4-bit and an 8-bit instance run
// directed and random divisions against a cycle-level behavioural model.
module tb_seq_divider;

`ifdef DIVIDER_DBZ_CHECK_EN
   localparam bit DBZ = 1'b1;
`else
   localparam bit DBZ = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       go4 = 1'b0, go8 = 1'b0;
   logic [3:0] x4 = '0, y4 = '0, q4, r4;
   logic [7:0] x8 = '0, y8 = '0, q8, r8;
   logic       done4, busy4, err4, done8, busy8, err8;
   logic [1:0] cs4, cs8;

   seq_divider #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .go(go4), .dividend(x4), .divisor(y4),
      .quotient(q4), .remainder(r4), .done(done4), .busy(busy4),
      .err(err4), .cs(cs4));

   seq_divider #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .go(go8), .dividend(x8), .divisor(y8),
      .quotient(q8), .remainder(r8), .done(done8), .busy(busy8),
      .err(err8), .cs(cs8));

   int errors = 0;
   int checks = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 dividing (left = edges remaining), 2 result shown.
   typedef struct {
      int mode;
      int left;
      int q, r, pq, pr;
      int err;
   } mdl_t;

   function automatic mdl_t step_m(mdl_t m, int w, bit r, bit g, int x, int y);
      int ones = (1 << w) - 1;
      if (r) begin
         m = '{default: 0};
         return m;
      end
      case (m.mode)
         0: if (g) begin
            if (DBZ && y == 0) begin
               m.mode = 2; m.q = ones; m.r = x; m.err = 1;
            end else begin
               m.mode = 1; m.left = w; m.err = 0;
               m.pq = (y == 0) ? ones : x / y;
               m.pr = (y == 0) ? x : x % y;
            end
         end
         1: begin
            m.left--;
            if (m.left == 0) begin m.mode = 2; m.q = m.pq; m.r = m.pr; end
         end
         default: if (!g) m.mode = 0;
      endcase
      return m;
   endfunction

   mdl_t m4 = '{default: 0};
   mdl_t m8 = '{default: 0};

   always @(posedge clk) begin
      m4 = step_m(m4, 4, rst, go4, int'(x4), int'(y4));
      m8 = step_m(m8, 8, rst, go8, int'(x8), int'(y8));
   end

   // Compare every cycle once reset has been applied
   always @(negedge clk) begin
      if (chk_on) begin
         chk("cs4", int'(cs4), m4.mode);
         chk("done4", int'(done4), int'(m4.mode == 2));
         chk("busy4", int'(busy4), int'(m4.mode == 1));
         chk("quot4", int'(q4), m4.q);
         chk("rem4", int'(r4), m4.r);
         chk("err4", int'(err4), m4.err);
         chk("cs8", int'(cs8), m8.mode);
         chk("done8", int'(done8), int'(m8.mode == 2));
         chk("busy8", int'(busy8), int'(m8.mode == 1));
         chk("quot8", int'(q8), m8.q);
         chk("rem8", int'(r8), m8.r);
         chk("err8", int'(err8), m8.err);
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic int o_done(int s); return s == 4 ? int'(done4) : int'(done8); endfunction
   function automatic int o_busy(int s); return s == 4 ? int'(busy4) : int'(busy8); endfunction
   function automatic int o_q(int s);    return s == 4 ? int'(q4) : int'(q8);       endfunction
   function automatic int o_r(int s);    return s == 4 ? int'(r4) : int'(r8);       endfunction
   function automatic int o_err(int s);  return s == 4 ? int'(err4) : int'(err8);   endfunction
   function automatic int o_cs(int s);   return s == 4 ? int'(cs4) : int'(cs8);     endfunction

   task automatic drive(input int s, input bit g, input int x, input int y);
      if (s == 4) begin go4 = g; x4 = 4'(x); y4 = 4'(y); end
      else        begin go8 = g; x8 = 8'(x); y8 = 8'(y); end
   endtask

   // Issue one division, hold go `hold` extra cycles in DONE, then drop go.
   // Returns edges-to-done and cycles seen busy. Ends at a negedge with go low
   // and the DUT still in DONE.
   task automatic op(input int s, input int x, input int y, input int hold,
                     input bit scramble, output int lat, output int bcnt);
      @(negedge clk);
      drive(s, 1'b1, x, y);
      lat = 0; bcnt = 0;
      forever begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (o_busy(s) != 0) bcnt++;
         if (o_done(s) != 0) break;
         if (scramble) drive(s, 1'($urandom_range(0, 1)) | 1'b1, $urandom, $urandom);
         if (lat > 40) begin
            chk("timeout_done", 0, 1);
            break;
         end
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_done", o_done(s), 1);
      end
      drive(s, 1'b0, x, y);
   endtask

   task automatic back_to_idle(input int s);
      @(negedge clk);
      chk("idle_cs", o_cs(s), 0);
   endtask

   int lat, bc;

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_on = 1'b1;
      chk("rst_q4", int'(q4), 0);
      chk("rst_cs4", int'(cs4), 0);
      chk("rst_done8", int'(done8), 0);
      rst = 1'b0;

      // 13/4 on the 4-bit unit: 5 edges, busy 4 cycles
      op(4, 13, 4, 0, 1'b0, lat, bc);
      chk("lat_13_4", lat, 5);
      chk("busy_13_4", bc, 4);
      chk("q_13_4", o_q(4), 3);
      chk("r_13_4", o_r(4), 1);
      back_to_idle(4);

      op(4, 15, 1, 0, 1'b0, lat, bc);
      chk("q_15_1", o_q(4), 15); chk("r_15_1", o_r(4), 0);
      back_to_idle(4);
      op(4, 7, 9, 0, 1'b0, lat, bc);
      chk("q_7_9", o_q(4), 0); chk("r_7_9", o_r(4), 7);
      back_to_idle(4);
      op(4, 9, 9, 0, 1'b0, lat, bc);
      chk("q_9_9", o_q(4), 1); chk("r_9_9", o_r(4), 0);
      back_to_idle(4);

      // 8-bit unit
      op(8, 200, 7, 0, 1'b0, lat, bc);
      chk("lat_200_7", lat, 9);
      chk("q_200_7", o_q(8), 28); chk("r_200_7", o_r(8), 4);
      back_to_idle(8);
      op(8, 255, 255, 0, 1'b0, lat, bc);
      chk("q_255_255", o_q(8), 1); chk("r_255_255", o_r(8), 0);
      back_to_idle(8);

      // go held through DONE: no restart
      op(4, 11, 3, 10, 1'b0, lat, bc);
      chk("q_hold", o_q(4), 3); chk("r_hold", o_r(4), 2);
      back_to_idle(4);

      // reset on the third iteration edge of 13/4
      @(negedge clk);
      drive(4, 1'b1, 13, 4);
      @(posedge clk);                       // E0
      repeat (2) begin @(negedge clk); @(posedge clk); end  // E1, E2
      @(negedge clk);
      rst = 1'b1;
      drive(4, 1'b0, 13, 4);
      @(posedge clk);                       // E3 under reset
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_cs", int'(cs4), 0);
      chk("rst_mid_q", int'(q4), 0);
      chk("rst_mid_r", int'(r4), 0);
      chk("rst_mid_busy", int'(busy4), 0);
      op(4, 6, 3, 0, 1'b0, lat, bc);
      chk("q_6_3", o_q(4), 2); chk("r_6_3", o_r(4), 0);
      back_to_idle(4);

      // zero divisor
      op(4, 10, 0, 0, 1'b0, lat, bc);
      chk("lat_10_0", lat, DBZ ? 1 : 5);
      chk("err_10_0", o_err(4), DBZ ? 1 : 0);
      chk("q_10_0", o_q(4), 15); chk("r_10_0", o_r(4), 10);
      back_to_idle(4);
      op(4, 5, 2, 0, 1'b0, lat, bc);
      chk("err_clear", o_err(4), 0);
      back_to_idle(4);

      // random operations, operands and go disturbed during iterations
      for (int n = 0; n < 60; n++) begin
         int s, w, x, y, mask;
         s = (n % 2 == 0) ? 4 : 8;
         w = s;
         mask = (1 << w) - 1;
         x = $urandom & mask;
         y = ($urandom_range(0, 5) == 0) ? 0 : ($urandom & mask);
         op(s, x, y, $urandom_range(0, 3), 1'b1, lat, bc);
         chk("rnd_q", o_q(s), (y == 0) ? mask : x / y);
         chk("rnd_r", o_r(s), (y == 0) ? x : x % y);
         chk("rnd_lat", lat, (DBZ && y == 0) ? 1 : w + 1);
         back_to_idle(s);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      @(negedge clk);
      chk_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
